// File: rtl/sipm_reader_pkg.sv
// Shared channel-state type, width helpers and height encoder for the SiPM reader.
package sipm_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_READY  = 2'd2,
    ST_DEAD   = 2'd3
  } ch_state_e;

  localparam int MAX_THR = 7;
  localparam int CNT_W   = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int height_width(input int n_thr);
    return $clog2(n_thr + 1);
  endfunction

  // 1-based index of the highest asserted comparator, 0 when none is set.
  function automatic logic [2:0] height_encode(input logic [MAX_THR-1:0] lvl);
    logic [2:0] h;
    h = 3'd0;
    for (int i = 0; i < MAX_THR; i++) begin
      if (lvl[i]) h = 3'(i + 1);
    end
    return h;
  endfunction

endpackage

// File: rtl/sipm_channel.sv
// One SiPM channel: comparator synchronizer, capture FSM, peak/timestamp latch.
// Optional pile-up tracking under SIPM_READER_PILEUP_EN.
module sipm_channel
  import sipm_reader_pkg::*;
#(
  parameter int N_THR         = 3,
  parameter int TIMESTAMP_LEN = 40,
  parameter int SETTLE_CYC    = 2,
  parameter int DEAD_CYC      = 4,
  localparam int HEIGHT_W     = height_width(N_THR)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic                     clear_i,
  input  logic [N_THR-1:0]         comp_i,
  input  logic [TIMESTAMP_LEN-1:0] counter_i,
  input  logic                     ack_i,
  output logic                     ready_o,
  output logic [TIMESTAMP_LEN-1:0] ts_o,
  output logic [HEIGHT_W-1:0]      height_o
`ifdef SIPM_READER_PILEUP_EN
  ,
  output logic                     pileup_o
`endif
);

  logic [N_THR-1:0]         meta_q, sync_q;
  ch_state_e                state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [HEIGHT_W-1:0]      peak_q;
  logic [HEIGHT_W-1:0]      enc_s;
  logic [TIMESTAMP_LEN-1:0] ts_q;

  assign enc_s = HEIGHT_W'(height_encode(MAX_THR'(sync_q)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= comp_i;
      sync_q <= meta_q;
    end
  end

  // Peak covers SETTLE_CYC samples starting with the entry edge; the edge that
  // moves to READY no longer samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      peak_q  <= '0;
      ts_q    <= '0;
    end else if (clear_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      peak_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en_i && (sync_q != '0)) begin
            state_q <= ST_SETTLE;
            ts_q    <= counter_i;
            peak_q  <= enc_s;
            cnt_q   <= CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (cnt_q >= CNT_W'(SETTLE_CYC)) begin
            state_q <= ST_READY;
          end else begin
            if (enc_s > peak_q) peak_q <= enc_s;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_READY: begin
          if (ack_i) begin
            state_q <= ST_DEAD;
            cnt_q   <= CNT_W'(1);
          end
        end
        ST_DEAD: begin
          if (cnt_q >= CNT_W'(DEAD_CYC)) begin
            if (sync_q == '0) state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready_o  = (state_q == ST_READY);
  assign ts_o     = ts_q;
  assign height_o = peak_q;

`ifdef SIPM_READER_PILEUP_EN
  logic seen_nz_q, pileup_q;

  // A fresh 0 -> non-zero edge while the record waits marks it as piled up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_nz_q <= 1'b0;
      pileup_q  <= 1'b0;
    end else begin
      seen_nz_q <= (sync_q != '0);
      if (clear_i || (state_q != ST_READY) || ack_i) begin
        pileup_q <= 1'b0;
      end else if ((sync_q != '0) && !seen_nz_q) begin
        pileup_q <= 1'b1;
      end
    end
  end

  assign pileup_o = pileup_q;
`endif

endmodule

// File: rtl/sipm_multi_reader.sv
// Multi-channel SiPM reader: N_CH channels, round-robin arbiter, registered record output.
// Defining SIPM_READER_PILEUP_EN adds the out_pileup port.
module sipm_multi_reader
  import sipm_reader_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int N_THR         = 3,
  parameter int TIMESTAMP_LEN = 40,
  parameter int SETTLE_CYC    = 2,
  parameter int DEAD_CYC      = 4,
  localparam int CH_W         = idx_width(N_CH),
  localparam int HEIGHT_W     = height_width(N_THR)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_latches,
  input  logic [N_CH*N_THR-1:0]    comparators_input,
  input  logic [TIMESTAMP_LEN-1:0] counter_input,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_channel,
  output logic [HEIGHT_W-1:0]      out_height,
  output logic [TIMESTAMP_LEN-1:0] out_timestamp
`ifdef SIPM_READER_PILEUP_EN
  ,
  output logic                     out_pileup
`endif
);

  logic [1:0]                               arm_q;
  logic [N_CH-1:0]                          ready_s, cand_s;
  logic [N_CH-1:0][TIMESTAMP_LEN-1:0]       ts_s;
  logic [N_CH-1:0][HEIGHT_W-1:0]            height_s;
  logic                                     hs_s, found_s;
  logic [CH_W-1:0]                          sel_s, idx_s, ptr_q;
  logic                                     valid_q;
  logic [CH_W-1:0]                          channel_q;
  logic [HEIGHT_W-1:0]                      height_q;
  logic [TIMESTAMP_LEN-1:0]                 ts_q;
`ifdef SIPM_READER_PILEUP_EN
  logic [N_CH-1:0]                          pileup_s;
  logic                                     pileup_q;
`endif

  assign hs_s = valid_q & out_ready;

  // Reset release is re-timed so captures start on the third edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_q <= 2'b00;
    end else begin
      arm_q <= {arm_q[0], 1'b1};
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    sipm_channel #(
      .N_THR        (N_THR),
      .TIMESTAMP_LEN(TIMESTAMP_LEN),
      .SETTLE_CYC   (SETTLE_CYC),
      .DEAD_CYC     (DEAD_CYC)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (arm_q[1]),
      .clear_i  (clear_latches),
      .comp_i   (comparators_input[c*N_THR +: N_THR]),
      .counter_i(counter_input),
      .ack_i    (hs_s && (channel_q == CH_W'(c))),
      .ready_o  (ready_s[c]),
      .ts_o     (ts_s[c]),
      .height_o (height_s[c])
`ifdef SIPM_READER_PILEUP_EN
      ,
      .pileup_o (pileup_s[c])
`endif
    );

    // The channel being handed off this edge is not eligible again.
    assign cand_s[c] = ready_s[c] && !(hs_s && (channel_q == CH_W'(c)));
  end

  always_comb begin
    found_s = 1'b0;
    sel_s   = ptr_q;
    idx_s   = ptr_q;
    for (int k = 1; k <= N_CH; k++) begin
      idx_s = CH_W'((int'(ptr_q) + k) % N_CH);
      if (!found_s && cand_s[idx_s]) begin
        found_s = 1'b1;
        sel_s   = idx_s;
      end
    end
  end

  // Record register reloads whenever it is empty or its record is being taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      channel_q <= '0;
      height_q  <= '0;
      ts_q      <= '1;
      ptr_q     <= '0;
`ifdef SIPM_READER_PILEUP_EN
      pileup_q  <= 1'b0;
`endif
    end else if (clear_latches) begin
      valid_q <= 1'b0;
    end else if (!valid_q || hs_s) begin
      valid_q <= found_s;
      if (found_s) begin
        channel_q <= sel_s;
        height_q  <= height_s[sel_s];
        ts_q      <= ts_s[sel_s];
        ptr_q     <= sel_s;
`ifdef SIPM_READER_PILEUP_EN
        pileup_q  <= pileup_s[sel_s];
`endif
      end
    end
  end

  assign out_valid     = valid_q;
  assign out_channel   = channel_q;
  assign out_height    = height_q;
  assign out_timestamp = ts_q;
`ifdef SIPM_READER_PILEUP_EN
  assign out_pileup    = pileup_q;
`endif

endmodule

// File: doc/sipm_multi_reader.md
SIPM_MULTI_READER -- requirements
Module: sipm_multi_reader

Interface
REQ-001 Parameter N_CH, default 4: number of SiPM channels, range 1..16.
REQ-002 Parameter N_THR, default 3: comparator thresholds per channel, range 1..7.
REQ-003 Parameter TIMESTAMP_LEN, default 40: timestamp width.
REQ-004 Parameter SETTLE_CYC, default 2: peak-collection window length in cycles, range 1..15.
REQ-005 Parameter DEAD_CYC, default 4: dead time after readout in cycles, range 0..15.
REQ-006 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port clear_latches, input, 1 bit: synchronous clear of all channels and pending records.
REQ-009 Port comparators_input, input, N_CH*N_THR bits: asynchronous comparator levels, channel c at bits [c*N_THR +: N_THR].
REQ-010 Port counter_input, input, TIMESTAMP_LEN bits: free-running time counter, synchronous to clk.
REQ-011 Port out_valid, output, 1 bit: record available.
REQ-012 Port out_ready, input, 1 bit: consumer accepts record.
REQ-013 Port out_channel, output, clog2(N_CH) bits (minimum 1): source channel of the record.
REQ-014 Port out_height, output, clog2(N_THR+1) bits: peak threshold level, 1..N_THR.
REQ-015 Port out_timestamp, output, TIMESTAMP_LEN bits: counter value at the first crossing.
REQ-016 Port out_pileup, output, 1 bit: pile-up flag; present only with SIPM_READER_PILEUP_EN.

Function
REQ-017 Each comparator bit SHALL pass through a 2-flop synchronizer; "sync" below means the synchronized vector.
REQ-018 Each channel FSM SHALL have the states IDLE, SETTLE, READY, DEAD.
REQ-019 IDLE->SETTLE on the first edge where sync != 0; counter_input is sampled on that same edge into the channel timestamp.
REQ-020 In SETTLE, peak SHALL equal the max of (index of highest set sync bit + 1) over SETTLE_CYC cycles, counting the entry edge; non-thermometer patterns use the highest set bit.
REQ-021 SETTLE->READY after SETTLE_CYC cycles.
REQ-022 A round-robin arbiter SHALL select among READY channels, starting after the last granted channel; out_valid asserts one cycle after selection.
REQ-023 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-024 On out_valid and out_ready both high, the granted channel moves READY->DEAD; the next record may be valid on the following cycle.
REQ-025 DEAD SHALL last DEAD_CYC cycles, then go to IDLE only once sync == 0; if sync != 0, the channel waits in DEAD.
REQ-026 Crossings arriving during SETTLE raise the peak only; crossings arriving during READY or DEAD are dropped.
REQ-027 clear_latches=1 SHALL force all channels to IDLE and deassert out_valid on the next edge; pending records are discarded.
REQ-028 If clear_latches=1 and a handshake occur on the same edge, the clear SHALL win; the record counts as delivered.
REQ-029 Timestamps SHALL be taken verbatim, with no wrap correction.

Reset
REQ-030 On rst_n=0: all channels IDLE, synchronizers 0, out_valid=0, out_channel=0, out_height=0, out_timestamp all ones, out_pileup=0, round-robin pointer at channel 0.
REQ-031 Reset release SHALL be synchronized internally; the first capture is possible on the third edge after release.

Configuration
REQ-032 Macro SIPM_READER_PILEUP_EN defined: a new rising (0->non-zero) sync transition in READY sets that channel's pileup bit, which is output with its record and cleared on handshake.
REQ-033 SIPM_READER_PILEUP_EN undefined: the out_pileup port and its logic SHALL be absent.

Structure
REQ-034 Package sipm_reader_pkg SHALL hold the channel-state enum, the height-encode function and the clog2-based width constants.
REQ-035 Per-channel synchronizer, FSM and capture SHALL be sub-module sipm_channel, instantiated N_CH times by generate; the arbiter and output register stay in the top level.

Verification (N_CH=4, N_THR=3, SETTLE_CYC=2, DEAD_CYC=4)
REQ-036 Ch1 inputs 3'b001 with counter=100 at the sync edge, out_ready=1 -> one record: ch=1, height=1, ts=100.
REQ-037 Ch2 inputs 001 then 111 on the next cycle -> height=3, ts = the counter at the first edge.
REQ-038 Ch0 and ch3 become READY on the same edge, pointer at 0 -> ch3 first, then ch0; with out_ready=0 for 5 cycles the outputs stay stable.
REQ-039 clear_latches pulsed while ch1 is in SETTLE -> no record; the channel re-arms and captures a later pulse correctly.
REQ-040 rst_n asserted mid-READY -> out_valid=0 and out_timestamp=all ones immediately (asynchronously).
REQ-041 PILEUP_EN: ch0 pulses again while READY -> record has pileup=1; the next record has pileup=0.
